dm9000a_bus_ctrl: RTL and testbench
===================================

Name: dm9000a_bus_ctrl

Overview:
Sequencer for the DM9000A host bus. It turns single register-access requests (index, write/read, data) into the two-phase DM9000A cycle. The first phase is an index write with CMD=0; the second is a data write or read with CMD=1. Strobe setup, pulse and hold times are programmable, and the block also sequences the chip hardware reset. It sits between the host logic and the DM9000A pin interface, driving that interface's data, CMD, RD_N, WR_N, CS_N and RST_N inputs.

Parameters:
SETUP_CYC, 1, cycles CS_N/CMD/data are stable before the strobe falls (≥1)
PULSE_CYC, 2, cycles RD_N/WR_N is held low (≥1)
HOLD_CYC, 1, cycles CS_N/CMD/data are held after the strobe rises (≥1)
RST_LOW_CYC, 4, cycles oENET_RST_N is held low during a reset sequence (≥1)
RST_WAIT_CYC, 8, cycles after RST_N rises before the first access is allowed (≥1)
CNT_W, 16, width of the shared timing counter; must hold the largest parameter value

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iSOFT_RST  in  1  single-cycle request to rerun the chip reset sequence
iREQ_VALID  in  1  request valid
oREQ_READY  out  1  request accepted when iREQ_VALID & oREQ_READY
iREQ_WR  in  1  1 = register write, 0 = register read
iREQ_IDX  in  8  DM9000A register index
iREQ_DATA  in  16  write data (ignored for reads)
oRSP_VALID  out  1  one-cycle pulse when an access completes
oRSP_DATA  out  16  read data; holds its last value after writes
oBUSY  out  1  high in every state except IDLE
oENET_DATA  out  16  data/index toward the pin interface
iENET_DATA  in  16  read data from the pin interface
oENET_CMD  out  1  0 = index phase, 1 = data phase
oENET_RD_N  out  1  read strobe
oENET_WR_N  out  1  write strobe
oENET_CS_N  out  1  chip select
oENET_RST_N  out  1  chip hardware reset

Behaviour:
- All outputs are registered.
- Reset values:
  - CS_N=1, RD_N=1, WR_N=1, CMD=0, RST_N=0.
  - oENET_DATA=0, oRSP_DATA=0.
  - oREQ_READY=0, oRSP_VALID=0, oBUSY=1.
  - State = RST_LOW, counter=0.
- States: RST_LOW, RST_WAIT, IDLE, IDX_SU, IDX_PW, IDX_HD, DAT_SU, DAT_PW, DAT_HD.
- One shared down-counter. Each timed state lasts exactly its parameter count, then advances.
- RST_LOW: RST_N=0 for RST_LOW_CYC cycles, then RST_WAIT.
- RST_WAIT: RST_N=1 for RST_WAIT_CYC cycles, then IDLE.
- IDLE:
  - oREQ_READY=1, oBUSY=0, CS_N=1.
  - On handshake, latch WR/IDX/DATA and go to IDX_SU. oREQ_READY drops the next cycle.
- IDX_SU / IDX_PW / IDX_HD:
  - CS_N=0, CMD=0, oENET_DATA={8'h00, IDX}.
  - WR_N=0 only in IDX_PW. The index phase is always a write.
- DAT_SU / DAT_PW / DAT_HD:
  - CS_N=0, CMD=1.
  - Write: oENET_DATA=DATA, WR_N=0 only in DAT_PW.
  - Read: RD_N=0 only in DAT_PW, and iENET_DATA is captured on the last DAT_PW cycle.
- CS_N stays low continuously from IDX_SU through DAT_HD, with no release between phases.
- Completion:
  - First cycle back in IDLE: CS_N=1, CMD=0, oRSP_VALID=1 for one cycle.
  - On a read, oRSP_DATA is updated in that same cycle.
- Latency: 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+1 cycles from the handshake edge to oRSP_VALID. With defaults this is 9.
- Back-to-back: a new request may be accepted in the same cycle oRSP_VALID is high. That gives at least one IDLE cycle with CS_N=1 between accesses.
- RD_N and WR_N are never low together, and never low in IDLE or the reset states.
- iSOFT_RST:
  - In IDLE it wins over a simultaneous iREQ_VALID (no handshake) and enters RST_LOW.
  - During an access it is latched and taken after the access completes, in the oRSP_VALID cycle. No request is accepted in that cycle.
  - Ignored in RST_LOW/RST_WAIT.
- iRST_N assertion at any time, including mid-access, forces the reset values immediately. The in-flight access is dropped with no oRSP_VALID.
- oENET_DATA is held at its last value when not in an access. The pin interface's tristate enable comes from WR_N only.

Test Plan:
- Power-up: release iRST_N → RST_N low for 4 cycles, high, then oREQ_READY rises 8 cycles later. No strobes are asserted before that.
- Write idx 0x1F, data 0x0001:
  - Cycles 1–4 after handshake: CS_N=0, CMD=0, DATA=0x001F, WR_N low in cycles 2–3.
  - Cycles 5–8: CMD=1, DATA=0x0001, WR_N low in cycles 6–7.
  - Cycle 9: CS_N=1, oRSP_VALID=1.
- Read idx 0x28 with the model driving iENET_DATA=0x0A46 during the data pulse → RD_N low in cycles 6–7, WR_N high throughout the data phase, oRSP_DATA=0x0A46 with oRSP_VALID in cycle 9.
- Back-to-back: a second write with iREQ_VALID held high is accepted in the oRSP_VALID cycle → exactly one CS_N-high cycle between accesses, second oRSP_VALID 9 cycles later.
- iSOFT_RST pulsed at cycle 3 of a write → the write completes normally with oRSP_VALID, then RST_N goes low for 4 cycles. iSOFT_RST and iREQ_VALID together in IDLE → no handshake, reset sequence runs.
- iRST_N asserted during DAT_PW → all outputs at reset values asynchronously, no oRSP_VALID. After release, the full reset sequence repeats.

Source files
------------

// File: rtl/dm9000a_bus_ctrl.sv
// DM9000A host bus sequencer: turns one register request into an index-write
// cycle (CMD=0) followed by a data write/read cycle (CMD=1), and runs the chip reset.
module dm9000a_bus_ctrl #(
   parameter int SETUP_CYC    = 1,
   parameter int PULSE_CYC    = 2,
   parameter int HOLD_CYC     = 1,
   parameter int RST_LOW_CYC  = 4,
   parameter int RST_WAIT_CYC = 8,
   parameter int CNT_W        = 16
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iSOFT_RST,
   input  logic        iREQ_VALID,
   output logic        oREQ_READY,
   input  logic        iREQ_WR,
   input  logic [7:0]  iREQ_IDX,
   input  logic [15:0] iREQ_DATA,
   output logic        oRSP_VALID,
   output logic [15:0] oRSP_DATA,
   output logic        oBUSY,
   output logic [15:0] oENET_DATA,
   input  logic [15:0] iENET_DATA,
   output logic        oENET_CMD,
   output logic        oENET_RD_N,
   output logic        oENET_WR_N,
   output logic        oENET_CS_N,
   output logic        oENET_RST_N
);

   typedef enum logic [3:0] {
      ST_RST_LOW, ST_RST_WAIT, ST_IDLE,
      ST_IDX_SU, ST_IDX_PW, ST_IDX_HD,
      ST_DAT_SU, ST_DAT_PW, ST_DAT_HD
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_wr;
   logic [7:0]         r_idx;
   logic [15:0]        r_data;
   logic [15:0]        r_rdData;
   logic               r_softPend;
   logic               r_csN, r_cmd, r_rdN, r_wrN, r_rstN;
   logic [15:0]        r_enetData, r_rspData;
   logic               r_rspValid, r_ready, r_busy;

   state_t             w_next;
   logic [CNT_W-1:0]   w_limit;
   logic               w_done, w_hs, w_softReq, w_access;
   logic               w_wr, w_inIdx, w_inDat;
   logic [7:0]         w_idx;
   logic [15:0]        w_data;

   // Outputs are registered from the next state, so each registered pin value
   // lines up exactly with the state it belongs to.
   always_comb begin
      w_limit   = '0;
      w_next    = r_state;
      w_access  = 1'b0;
      w_softReq = iSOFT_RST | r_softPend;
      w_hs      = (r_state == ST_IDLE) & iREQ_VALID & r_ready & ~w_softReq;
      case (r_state)
         ST_RST_LOW:  w_limit = CNT_W'(RST_LOW_CYC - 1);
         ST_RST_WAIT: w_limit = CNT_W'(RST_WAIT_CYC - 1);
         ST_IDX_SU, ST_DAT_SU: w_limit = CNT_W'(SETUP_CYC - 1);
         ST_IDX_PW, ST_DAT_PW: w_limit = CNT_W'(PULSE_CYC - 1);
         ST_IDX_HD, ST_DAT_HD: w_limit = CNT_W'(HOLD_CYC - 1);
         default:     w_limit = '0;
      endcase
      w_done = (r_cnt == w_limit);
      case (r_state)
         ST_RST_LOW:  if (w_done) w_next = ST_RST_WAIT;
         ST_RST_WAIT: if (w_done) w_next = ST_IDLE;
         ST_IDLE: begin
            if (w_softReq)  w_next = ST_RST_LOW;
            else if (w_hs)  w_next = ST_IDX_SU;
         end
         ST_IDX_SU:   begin w_access = 1'b1; if (w_done) w_next = ST_IDX_PW; end
         ST_IDX_PW:   begin w_access = 1'b1; if (w_done) w_next = ST_IDX_HD; end
         ST_IDX_HD:   begin w_access = 1'b1; if (w_done) w_next = ST_DAT_SU; end
         ST_DAT_SU:   begin w_access = 1'b1; if (w_done) w_next = ST_DAT_PW; end
         ST_DAT_PW:   begin w_access = 1'b1; if (w_done) w_next = ST_DAT_HD; end
         ST_DAT_HD:   begin w_access = 1'b1; if (w_done) w_next = ST_IDLE; end
         default:     w_next = ST_RST_LOW;
      endcase
      w_wr    = w_hs ? iREQ_WR   : r_wr;
      w_idx   = w_hs ? iREQ_IDX  : r_idx;
      w_data  = w_hs ? iREQ_DATA : r_data;
      w_inIdx = (w_next == ST_IDX_SU) | (w_next == ST_IDX_PW) | (w_next == ST_IDX_HD);
      w_inDat = (w_next == ST_DAT_SU) | (w_next == ST_DAT_PW) | (w_next == ST_DAT_HD);
   end

   // State, counter, request latch and all registered outputs.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state    <= ST_RST_LOW;
         r_cnt      <= '0;
         r_wr       <= 1'b0;
         r_idx      <= '0;
         r_data     <= '0;
         r_rdData   <= '0;
         r_softPend <= 1'b0;
         r_csN      <= 1'b1;
         r_cmd      <= 1'b0;
         r_rdN      <= 1'b1;
         r_wrN      <= 1'b1;
         r_rstN     <= 1'b0;
         r_enetData <= '0;
         r_rspData  <= '0;
         r_rspValid <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || (r_state == ST_IDLE))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_hs) begin
            r_wr   <= iREQ_WR;
            r_idx  <= iREQ_IDX;
            r_data <= iREQ_DATA;
         end
         // A soft reset seen mid-access waits until the access has finished.
         r_softPend <= w_access ? (r_softPend | iSOFT_RST) : 1'b0;
         if ((r_state == ST_DAT_PW) && w_done && !r_wr)
            r_rdData <= iENET_DATA;
         r_csN  <= ~(w_inIdx | w_inDat);
         r_cmd  <= w_inDat;
         r_wrN  <= ~((w_next == ST_IDX_PW) | ((w_next == ST_DAT_PW) & w_wr));
         r_rdN  <= ~((w_next == ST_DAT_PW) & ~w_wr);
         r_rstN <= (w_next != ST_RST_LOW);
         if (w_inIdx)
            r_enetData <= {8'h00, w_idx};
         else if (w_inDat && w_wr)
            r_enetData <= w_data;
         r_rspValid <= (r_state == ST_DAT_HD) && (w_next == ST_IDLE);
         if ((r_state == ST_DAT_HD) && (w_next == ST_IDLE) && !r_wr)
            r_rspData <= r_rdData;
         r_ready <= (w_next == ST_IDLE) && !((r_state == ST_DAT_HD) && w_softReq);
         r_busy  <= (w_next != ST_IDLE);
      end
   end

   assign oREQ_READY  = r_ready;
   assign oRSP_VALID  = r_rspValid;
   assign oRSP_DATA   = r_rspData;
   assign oBUSY       = r_busy;
   assign oENET_DATA  = r_enetData;
   assign oENET_CMD   = r_cmd;
   assign oENET_RD_N  = r_rdN;
   assign oENET_WR_N  = r_wrN;
   assign oENET_CS_N  = r_csN;
   assign oENET_RST_N = r_rstN;

endmodule

// File: tb/tb_dm9000a_bus_ctrl.sv
// Directed bench for dm9000a_bus_ctrl: table of register accesses checked
// cycle by cycle, plus hand-written reset and soft-reset sequences.
module tb_dm9000a_bus_ctrl;

   logic        iCLK = 1'b0;
   logic        iRST_N, iSOFT_RST, iREQ_VALID, iREQ_WR;
   logic [7:0]  iREQ_IDX;
   logic [15:0] iREQ_DATA, iENET_DATA;
   logic        oREQ_READY, oRSP_VALID, oBUSY;
   logic [15:0] oRSP_DATA, oENET_DATA;
   logic        oENET_CMD, oENET_RD_N, oENET_WR_N, oENET_CS_N, oENET_RST_N;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  idx;
      logic [15:0] data;
      logic [15:0] rdVal;
      logic [15:0] expRsp;
   } vec_t;

   vec_t vecs[5];
   vec_t extra;

   dm9000a_bus_ctrl dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iSOFT_RST(iSOFT_RST),
      .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
      .iREQ_WR(iREQ_WR), .iREQ_IDX(iREQ_IDX), .iREQ_DATA(iREQ_DATA),
      .oRSP_VALID(oRSP_VALID), .oRSP_DATA(oRSP_DATA), .oBUSY(oBUSY),
      .oENET_DATA(oENET_DATA), .iENET_DATA(iENET_DATA),
      .oENET_CMD(oENET_CMD), .oENET_RD_N(oENET_RD_N), .oENET_WR_N(oENET_WR_N),
      .oENET_CS_N(oENET_CS_N), .oENET_RST_N(oENET_RST_N)
   );

   always #5 iCLK = ~iCLK;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " ctl"},
                  {8'd0, oENET_CS_N, oENET_RD_N, oENET_WR_N, oENET_CMD,
                   oENET_RST_N, oREQ_READY, oRSP_VALID, oBUSY},
                  16'b0000_0000_1110_0001);
      checkOutput({tag, " enet_data"}, oENET_DATA, 16'h0000);
      checkOutput({tag, " rsp_data"}, oRSP_DATA, 16'h0000);
   endtask

   // Starts at a sample where RST_N is expected low; counts low cycles, then
   // wait cycles until READY, watching that no strobe or chip select moves.
   task automatic checkResetSeq(input string tag);
      int lowCnt = 0;
      int waitCnt = 0;
      bit strobe = 0;
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         if (!oENET_CS_N || !oENET_RD_N || !oENET_WR_N) strobe = 1;
         if (!oENET_RST_N) lowCnt++;
         else if (oREQ_READY) done = 1;
         else waitCnt++;
         if (!done) tick();
      end
      checkOutput({tag, " ready reached"}, {15'd0, done}, 16'd1);
      checkOutput({tag, " rst low cycles"}, 16'(lowCnt), 16'd4);
      checkOutput({tag, " rst wait cycles"}, 16'(waitCnt), 16'd8);
      checkOutput({tag, " strobes quiet"}, {15'd0, strobe}, 16'd0);
   endtask

   // Handshake one request, then check the 9 cycles that follow it.
   task automatic applyStimulus(input string tag, input vec_t v, input int softAt,
                                input int abortAt, input bit holdValid);
      int waitCyc = 0;
      logic [15:0] expCtl, expData;
      iREQ_WR    = v.wr;
      iREQ_IDX   = v.idx;
      iREQ_DATA  = v.data;
      iREQ_VALID = 1'b1;
      while (oREQ_READY !== 1'b1 && waitCyc < 50) begin
         tick();
         waitCyc++;
      end
      checkOutput({tag, " ready"}, {15'd0, oREQ_READY}, 16'd1);
      if (oREQ_READY !== 1'b1) begin
         iREQ_VALID = 1'b0;
         return;
      end
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) begin
            iREQ_VALID = holdValid;
            iREQ_IDX   = ~v.idx;
            iREQ_DATA  = ~v.data;
         end
         iSOFT_RST = (c == softAt);
         if (!v.wr) iENET_DATA = (c == 7) ? v.rdVal : ((c == 6) ? 16'hDEAD : 16'h0BAD);
         expCtl = {9'd0,
                   1'(c == 9),
                   1'(c >= 5 && c <= 8),
                   1'(!(c == 2 || c == 3 || (v.wr && (c == 6 || c == 7)))),
                   1'(!(!v.wr && (c == 6 || c == 7))),
                   1'(c == 9),
                   1'(c == 9 && softAt == 0),
                   1'(c != 9)};
         expData = (c <= 4 || !v.wr) ? {8'h00, v.idx} : v.data;
         checkOutput($sformatf("%s c%0d ctl", tag, c),
                     {9'd0, oENET_CS_N, oENET_CMD, oENET_WR_N, oENET_RD_N,
                      oRSP_VALID, oREQ_READY, oBUSY}, expCtl);
         checkOutput($sformatf("%s c%0d enet_data", tag, c), oENET_DATA, expData);
         if (c == 9) checkOutput({tag, " rsp_data"}, oRSP_DATA, v.expRsp);
         if (c == abortAt) begin
            iSOFT_RST = 1'b0;
            return;
         end
      end
      iSOFT_RST = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h1F, 16'h0001, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 8'h28, 16'h0000, 16'h0A46, 16'h0A46};
      vecs[2] = '{1'b1, 8'h05, 16'hBEEF, 16'h0000, 16'h0A46};
      vecs[3] = '{1'b0, 8'hFE, 16'h0000, 16'h1234, 16'h1234};
      vecs[4] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000, 16'h1234};

      iRST_N = 1'b0; iSOFT_RST = 1'b0; iREQ_VALID = 1'b0; iREQ_WR = 1'b0;
      iREQ_IDX = '0; iREQ_DATA = '0; iENET_DATA = '0;
      repeat (3) tick();
      checkResetValues("por");
      iRST_N = 1'b1;
      checkResetSeq("powerup");

      // Consecutive entries run back to back; entry 1 also leaves VALID high.
      for (int i = 0; i < 5; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i], 0, 0, i == 1);

      extra = '{1'b1, 8'h31, 16'h00C3, 16'h0000, 16'h1234};
      applyStimulus("softmid", extra, 3, 0, 1'b0);
      tick();
      checkResetSeq("softmid");

      iSOFT_RST = 1'b1; iREQ_VALID = 1'b1; iREQ_WR = 1'b1;
      iREQ_IDX = 8'h44; iREQ_DATA = 16'h4444;
      tick();
      iSOFT_RST = 1'b0; iREQ_VALID = 1'b0;
      checkOutput("softidle ctl", {12'd0, oENET_CS_N, oENET_RST_N, oREQ_READY, oBUSY},
                  16'b0000_0000_0000_1001);
      checkResetSeq("softidle");

      extra = '{1'b1, 8'h55, 16'hA5A5, 16'h0000, 16'h1234};
      applyStimulus("abort", extra, 0, 6, 1'b0);
      #2 iRST_N = 1'b0;
      #1 checkResetValues("abort async");
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("abort hold%0d", k), {14'd0, oRSP_VALID, oENET_RST_N}, 16'd0);
      end
      iRST_N = 1'b1;
      checkResetSeq("abort");

      extra = '{1'b0, 8'h10, 16'h0000, 16'h5A5A, 16'h5A5A};
      applyStimulus("post", extra, 0, 0, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
